// File: rtl/inst_sram_resp.sv
// Single-port instruction SRAM with a power-up fill sweep, byte write enables,
// read-first registered read data and a sticky out-of-range/misaligned flag.
module inst_sram_resp #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'hbfc00000,
    parameter logic [31:0] FILL_WORD  = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        sram_busy,
    output logic        addr_err
);
    localparam int          DEPTH = 1 << ADDR_WIDTH;
    localparam logic [32:0] SPAN  = 33'(DEPTH) * 33'd4;

    typedef enum logic {INIT, READY} state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  init_cnt_reg, init_cnt_next;
    logic [31:0]            off;
    logic                   access_valid;
    logic [ADDR_WIDTH-1:0]  acc_idx;
    logic                   req;
    logic [ADDR_WIDTH-1:0]  wr_idx;
    logic [31:0]            rd_word;

    // Offset is taken with 32-bit wrap, so addresses below BASE_ADDR land far out of range.
    always_comb begin
        off          = sram_addr - BASE_ADDR;
        access_valid = ({1'b0, off} < SPAN) && (sram_addr[1:0] == 2'b00);
        acc_idx      = off[ADDR_WIDTH+1:2];
        req          = (state_reg == READY) && sram_en;
        wr_idx       = (state_reg == INIT) ? init_cnt_reg : acc_idx;
    end

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        case (state_reg)
            INIT: begin
                init_cnt_next = init_cnt_reg + ADDR_WIDTH'(1);
                if (&init_cnt_reg) state_next = READY;
            end
            READY: ;
            default: state_next = INIT;
        endcase
    end

    // One byte-wide array per lane keeps each lane write enable independent.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic       lane_we;
            logic [7:0] lane_wdata;

            assign lane_we    = (state_reg == INIT) || (req && access_valid && sram_wen[gi]);
            assign lane_wdata = (state_reg == INIT) ? FILL_WORD[8*gi +: 8] : sram_wdata[8*gi +: 8];

            always_ff @(posedge clk) begin
                if (lane_we) lane_mem[wr_idx] <= lane_wdata;
            end

            assign rd_word[8*gi +: 8] = lane_mem[acc_idx];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= INIT;
            init_cnt_reg <= '0;
            sram_rdata   <= 32'h0;
            addr_err     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
            if (req) sram_rdata <= access_valid ? rd_word : 32'h0;
            if (req && !access_valid) addr_err <= 1'b1;
        end
    end

    assign sram_busy = (state_reg == INIT);

endmodule

// File: tb/tb_inst_sram_resp.sv
// Self-checking bench for inst_sram_resp: reset/sweep timing, a directed vector
// table, reset mid-sweep, and randomized traffic against a word-array model.
module tb_inst_sram_resp;
    localparam logic [31:0] BASE  = 32'hbfc00000;
    localparam logic [31:0] FILL  = 32'h00000000;
    localparam int          WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sram_en = 1'b0;
    logic [3:0]  sram_wen = 4'h0;
    logic [31:0] sram_addr = 32'h0;
    logic [31:0] sram_wdata = 32'h0;
    logic [31:0] sram_rdata;
    logic        sram_busy;
    logic        addr_err;

    inst_sram_resp dut (
        .clk        (clk),
        .reset      (reset),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_busy  (sram_busy),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_mem [WORDS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata);
        @(negedge clk);
        sram_en    = en;
        sram_wen   = wen;
        sram_addr  = addr;
        sram_wdata = wdata;
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy drops; a stuck busy ends the wait as a miscount.
    task automatic sweep_and_check(input string tag);
        int n;
        n = 0;
        while (sram_busy === 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'd1024);
        check({tag, "_rdata_after_sweep"}, sram_rdata, 32'h0);
        check({tag, "_err_after_sweep"}, {31'h0, addr_err}, 32'h0);
        for (int i = 0; i < WORDS; i++) model_mem[i] = FILL;
        @(negedge clk);
        sram_en = 1'b0;
    endtask

    task automatic add(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] er, input logic ee);
        vec_t v;
        v.en = en; v.wen = wen; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        exp_err;
        logic [31:0] exp_rd;

        add(1, 4'h0, 32'hbfc00ffc, 32'h0,          32'h00000000, 0);
        add(1, 4'hf, 32'hbfc00010, 32'h24080001,   32'h00000000, 0);
        add(1, 4'h0, 32'hbfc00010, 32'h0,          32'h24080001, 0);
        for (int i = 0; i < 5; i++)
            add(0, 4'hf, 32'hbfc00010, 32'hffffffff, 32'h24080001, 0);
        add(1, 4'hf, 32'hbfc00010, 32'h11223344,   32'h24080001, 0);
        add(1, 4'h5, 32'hbfc00010, 32'hAABBCCDD,   32'h11223344, 0);
        add(1, 4'h0, 32'hbfc00010, 32'h0,          32'h11BB33DD, 0);
        add(1, 4'h0, 32'hbfc00000, 32'h0,          32'h00000000, 0);
        add(1, 4'hf, 32'hbfc01000, 32'hdeadbeef,   32'h00000000, 1);
        add(1, 4'h0, 32'hbfc00002, 32'h0,          32'h00000000, 1);
        add(1, 4'hf, 32'hbfbffffc, 32'hcafef00d,   32'h00000000, 1);
        add(1, 4'h0, 32'hbfc00010, 32'h0,          32'h11BB33DD, 1);
        add(1, 4'h0, 32'hbfc00ffc, 32'h0,          32'h00000000, 1);

        // Power-up: reset state, then requests during the sweep must be ignored.
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",  {31'h0, sram_busy}, 32'h1);
        check("reset_rdata", sram_rdata, 32'h0);
        check("reset_err",   {31'h0, addr_err}, 32'h0);
        @(negedge clk);
        sram_en = 1'b1; sram_wen = 4'hf; sram_addr = 32'hbfc01000; sram_wdata = 32'hffffffff;
        reset = 1'b0;
        sweep_and_check("powerup");

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
            $display("vec %0d: en=%0b wen=%h addr=%08h wdata=%08h -> rdata=%08h err=%0b",
                     i, vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata, sram_rdata, addr_err);
            check($sformatf("vec%0d_rdata", i), sram_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'h0, addr_err}, {31'h0, vecs[i].exp_err});
        end

        // Asynchronous reset while READY with nonzero rdata and addr_err set.
        @(negedge clk);
        sram_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_reset_busy",  {31'h0, sram_busy}, 32'h1);
        check("async_reset_rdata", sram_rdata, 32'h0);
        check("async_reset_err",   {31'h0, addr_err}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (500) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midsweep_reset_busy", {31'h0, sram_busy}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        sweep_and_check("restart");

        // Randomized traffic; invalid addresses only late so addr_err stays informative.
        exp_err = 1'b0;
        exp_rd  = 32'h0;
        for (int i = 0; i < 200; i++) begin
            logic        en;
            logic [3:0]  wen;
            logic [31:0] addr, wdata, off;
            int          r;
            en    = ($urandom_range(0, 3) != 0);
            wen   = 4'($urandom);
            wdata = $urandom;
            r     = (i >= 150) ? $urandom_range(0, 9) : $urandom_range(2, 9);
            if (r == 0)
                addr = BASE + 32'h1000 + (32'($urandom_range(0, 255)) << 2);
            else if (r == 1)
                addr = BASE + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(1, 3));
            else if (r == 2)
                addr = BASE + (32'($urandom_range(0, WORDS - 1)) << 2);
            else
                addr = BASE + (32'($urandom_range(0, 7)) << 2);

            if (en) begin
                off = addr - BASE;
                if (off < 32'(WORDS * 4) && addr[1:0] == 2'b00) begin
                    exp_rd = model_mem[off >> 2];
                    for (int b = 0; b < 4; b++)
                        if (wen[b]) model_mem[off >> 2][8*b +: 8] = wdata[8*b +: 8];
                end else begin
                    exp_rd  = 32'h0;
                    exp_err = 1'b1;
                end
            end

            drive(en, wen, addr, wdata);
            $display("rnd %0d: en=%0b wen=%h addr=%08h wdata=%08h -> rdata=%08h err=%0b",
                     i, en, wen, addr, wdata, sram_rdata, addr_err);
            check($sformatf("rnd%0d_rdata", i), sram_rdata, exp_rd);
            check($sformatf("rnd%0d_err", i), {31'h0, addr_err}, {31'h0, exp_err});
            check($sformatf("rnd%0d_busy", i), {31'h0, sram_busy}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
